// File: rtl/tile_seq_gemm.sv
// Tile sequencer for C = A x B: walks (mi, ni, ki) tiles issuing load/compute/store handshakes.
// Optional busy/stall performance counters are built when TILE_SEQ_PERF_EN is defined.
module tile_seq_gemm #(
    parameter int TILE       = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DIM_WIDTH  = 16,
    localparam int TW        = $clog2(TILE) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  cfg_m,
    input  logic [DIM_WIDTH-1:0]  cfg_n,
    input  logic [DIM_WIDTH-1:0]  cfg_k,
    input  logic [ADDR_WIDTH-1:0] cfg_base_a,
    input  logic [ADDR_WIDTH-1:0] cfg_base_b,
    input  logic [ADDR_WIDTH-1:0] cfg_base_c,
    input  logic [DIM_WIDTH-1:0]  cfg_ld_a,
    input  logic [DIM_WIDTH-1:0]  cfg_ld_b,
    input  logic [DIM_WIDTH-1:0]  cfg_ld_c,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  ld_req,
    output logic                  ld_sel,
    output logic [ADDR_WIDTH-1:0] ld_addr,
    output logic [TW-1:0]         ld_rows,
    output logic [TW-1:0]         ld_cols,
    output logic [DIM_WIDTH-1:0]  ld_stride,
    input  logic                  ld_ack,
    output logic                  cmp_start,
    output logic                  cmp_first,
    input  logic                  cmp_ack,
    output logic                  st_req,
    output logic [ADDR_WIDTH-1:0] st_addr,
    output logic [TW-1:0]         st_rows,
    output logic [TW-1:0]         st_cols,
    output logic [DIM_WIDTH-1:0]  st_stride,
    input  logic                  st_ack,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stall
);
    localparam int LG = $clog2(TILE);
    localparam logic [ADDR_WIDTH-1:0] TILE_A = ADDR_WIDTH'(TILE);
    localparam logic [DIM_WIDTH-1:0]  TILE_D = DIM_WIDTH'(TILE);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_STORE, S_FIN
    } state_t;

    state_t state, state_nxt;
    logic acked, err_q;
    logic [DIM_WIDTH-1:0]  n_s, k_s, ld_a_s, ld_b_s, ld_c_s;
    logic [ADDR_WIDTH-1:0] base_b_s;
    logic [DIM_WIDTH-1:0]  ki, m_rem, n_rem, k_rem;
    logic [ADDR_WIDTH-1:0] a_row, b_row, c_row, k_off, n_off;
    logic last_m, last_n, last_k, any_zero, ack_hit, accept;

    function automatic logic [TW-1:0] clip(input logic [DIM_WIDTH-1:0] r);
        return (r >= TILE_D) ? TW'(TILE) : r[TW-1:0];
    endfunction

    assign last_m   = m_rem <= TILE_D;
    assign last_n   = n_rem <= TILE_D;
    assign last_k   = k_rem <= TILE_D;
    assign any_zero = (m_rem == '0) || (n_rem == '0) || (k_rem == '0);
    assign accept   = (state == S_IDLE) && start;
    assign ack_hit  = (ld_req & ld_ack) | (cmp_start & cmp_ack) | (st_req & st_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Each request state spends one extra cycle after its ack with req low,
    // so req drops for a cycle before the next state's req rises.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (start) state_nxt = S_CHECK;
            S_CHECK:   state_nxt = any_zero ? S_FIN : S_LOAD_A;
            S_LOAD_A:  if (acked) state_nxt = S_LOAD_B;
            S_LOAD_B:  if (acked) state_nxt = S_COMPUTE;
            S_COMPUTE: if (acked) state_nxt = last_k ? S_STORE : S_LOAD_A;
            S_STORE:   if (acked) state_nxt = (last_m && last_n) ? S_FIN : S_LOAD_A;
            S_FIN:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0; done = 1'b0; err = 1'b0;
        ld_req = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_rows = '0; ld_cols = '0; ld_stride = '0;
        cmp_start = 1'b0; cmp_first = 1'b0;
        st_req = 1'b0; st_addr = '0; st_rows = '0; st_cols = '0; st_stride = '0;
        unique case (state)
            S_CHECK: busy = 1'b1;
            S_LOAD_A: begin
                busy = 1'b1; ld_req = !acked;
                ld_addr = a_row + k_off; ld_rows = clip(m_rem); ld_cols = clip(k_rem);
                ld_stride = ld_a_s;
            end
            S_LOAD_B: begin
                busy = 1'b1; ld_req = !acked; ld_sel = 1'b1;
                ld_addr = b_row + n_off; ld_rows = clip(k_rem); ld_cols = clip(n_rem);
                ld_stride = ld_b_s;
            end
            S_COMPUTE: begin
                busy = 1'b1; cmp_start = !acked; cmp_first = !acked && (ki == '0);
            end
            S_STORE: begin
                busy = 1'b1; st_req = !acked;
                st_addr = c_row + n_off; st_rows = clip(m_rem); st_cols = clip(n_rem);
                st_stride = ld_c_s;
            end
            S_FIN: begin
                done = 1'b1; err = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acked <= 1'b0; err_q <= 1'b0;
            n_s <= '0; k_s <= '0; ld_a_s <= '0; ld_b_s <= '0; ld_c_s <= '0; base_b_s <= '0;
            ki <= '0; m_rem <= '0; n_rem <= '0; k_rem <= '0;
            a_row <= '0; b_row <= '0; c_row <= '0; k_off <= '0; n_off <= '0;
        end else begin
            acked <= ack_hit;
            if (state == S_CHECK && any_zero) err_q <= 1'b1;
            if (accept) begin
                err_q <= 1'b0;
                n_s <= cfg_n; k_s <= cfg_k;
                ld_a_s <= cfg_ld_a; ld_b_s <= cfg_ld_b; ld_c_s <= cfg_ld_c;
                base_b_s <= cfg_base_b;
                ki <= '0; m_rem <= cfg_m; n_rem <= cfg_n; k_rem <= cfg_k;
                a_row <= cfg_base_a; b_row <= cfg_base_b; c_row <= cfg_base_c;
                k_off <= '0; n_off <= '0;
            end else if (state == S_COMPUTE && acked) begin
                if (last_k) begin
                    ki <= '0; k_off <= '0; k_rem <= k_s; b_row <= base_b_s;
                end else begin
                    ki <= ki + 1'b1; k_off <= k_off + TILE_A; k_rem <= k_rem - TILE_D;
                    b_row <= b_row + (ADDR_WIDTH'(ld_b_s) << LG);
                end
            end else if (state == S_STORE && acked) begin
                if (last_n) begin
                    n_off <= '0; n_rem <= n_s;
                    if (!last_m) begin
                        m_rem <= m_rem - TILE_D;
                        a_row <= a_row + (ADDR_WIDTH'(ld_a_s) << LG);
                        c_row <= c_row + (ADDR_WIDTH'(ld_c_s) << LG);
                    end
                end else begin
                    n_off <= n_off + TILE_A; n_rem <= n_rem - TILE_D;
                end
            end
        end
    end

`ifdef TILE_SEQ_PERF_EN
    logic [31:0] cyc_q, stall_q;
    logic stall_now;
    assign stall_now = (ld_req & !ld_ack) | (cmp_start & !cmp_ack) | (st_req & !st_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0; stall_q <= '0;
        end else if (accept) begin
            cyc_q <= '0; stall_q <= '0;
        end else begin
            if (busy && cyc_q != '1)        cyc_q   <= cyc_q + 1'b1;
            if (stall_now && stall_q != '1) stall_q <= stall_q + 1'b1;
        end
    end
    assign perf_cycles = cyc_q;
    assign perf_stall  = stall_q;
`else
    assign perf_cycles = '0;
    assign perf_stall  = '0;
`endif
endmodule
